// File: rtl/pipeline_pkg.sv
// Shared pipeline types: B.cond encodings, the NZCV flag record and the
// registered EX/MEM control bundle.
package pipeline_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch_taken;
    } ctrl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bus: EX-side instruction fields in, registered MEM-side
// fields out. The stage itself uses the slave view.
interface ex_mem_stage_if #(
    parameter int WIDTH = 64,
    parameter int REG_W = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             set_flags;
    logic             is_cbz;
    logic             is_bcond;
    logic [3:0]       cond;
    logic [WIDTH-1:0] store_data;
    logic [REG_W-1:0] dest_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;

    logic             out_valid;
    logic             out_reg_write;
    logic             out_mem_read;
    logic             out_mem_write;
    logic             out_mem_to_reg;
    logic [WIDTH-1:0] out_alu_result;
    logic [WIDTH-1:0] out_store_data;
    logic [REG_W-1:0] out_dest_reg;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             branch_taken;

    modport master (
        output in_valid, alu_result, alu_carry, alu_overflow, set_flags,
               is_cbz, is_bcond, cond, store_data, dest_reg,
               reg_write, mem_read, mem_write, mem_to_reg,
        input  out_valid, out_reg_write, out_mem_read, out_mem_write,
               out_mem_to_reg, out_alu_result, out_store_data, out_dest_reg,
               flag_n, flag_z, flag_c, flag_v, branch_taken
    );

    modport slave (
        input  in_valid, alu_result, alu_carry, alu_overflow, set_flags,
               is_cbz, is_bcond, cond, store_data, dest_reg,
               reg_write, mem_read, mem_write, mem_to_reg,
        output out_valid, out_reg_write, out_mem_read, out_mem_write,
               out_mem_to_reg, out_alu_result, out_store_data, out_dest_reg,
               flag_n, flag_z, flag_c, flag_v, branch_taken
    );
endinterface

// File: rtl/cond_check.sv
// Combinational B.cond evaluator against an NZCV flag record.
import pipeline_pkg::*;

module cond_check (
    input  cond_t  cond,
    input  flags_t flags,
    output logic   cond_true
);

    // Decode the condition code into a single pass/fail bit.
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = !flags.z;
            COND_HS: cond_true = flags.c;
            COND_LO: cond_true = !flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = !flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = !flags.v;
            COND_HI: cond_true = flags.c && !flags.z;
            COND_LS: cond_true = !(flags.c && !flags.z);
            COND_GE: cond_true = (flags.n == flags.v);
            COND_LT: cond_true = (flags.n != flags.v);
            COND_GT: cond_true = !flags.z && (flags.n == flags.v);
            COND_LE: cond_true = !(!flags.z && (flags.n == flags.v));
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b1;
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV flag register and the
// registered branch decision. Flush beats stall; stall freezes everything.
import pipeline_pkg::*;

module ex_mem_stage #(
    parameter int WIDTH = 64,
    parameter int REG_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    ex_mem_stage_if.slave  bus
);

    ctrl_t            ctrl_d, ctrl_q;
    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic [WIDTH-1:0] store_data_d, store_data_q;
    logic [REG_W-1:0] dest_reg_d, dest_reg_q;
    flags_t           flags_d, flags_q;

    logic res_z;
    logic res_n;
    logic cond_true;

    assign res_z = ~|bus.alu_result;
    assign res_n = bus.alu_result[WIDTH-1];

    // Branch condition sees the flags as they stood before this edge.
    cond_check u_cond_check (
        .cond      (cond_t'(bus.cond)),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    // Next-state: hold by default, bubble on flush, capture when advancing.
    always_comb begin
        ctrl_d       = ctrl_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        dest_reg_d   = dest_reg_q;
        flags_d      = flags_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d.valid        = bus.in_valid;
            ctrl_d.reg_write    = bus.reg_write  & bus.in_valid;
            ctrl_d.mem_write    = bus.mem_write  & bus.in_valid;
            // a store never travels with a load; the store wins
            ctrl_d.mem_read     = bus.mem_read   & bus.in_valid & ~bus.mem_write;
            ctrl_d.mem_to_reg   = bus.mem_to_reg & bus.in_valid;
            ctrl_d.branch_taken = bus.in_valid &
                                  ((bus.is_bcond & cond_true) | (bus.is_cbz & res_z));
            alu_result_d        = bus.alu_result;
            store_data_d        = bus.store_data;
            dest_reg_d          = bus.dest_reg;
            if (bus.in_valid && bus.set_flags) begin
                flags_d = '{n: res_n, z: res_z, c: bus.alu_carry, v: bus.alu_overflow};
            end
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            alu_result_q <= '0;
            store_data_q <= '0;
            dest_reg_q   <= '0;
            flags_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            dest_reg_q   <= dest_reg_d;
            flags_q      <= flags_d;
        end
    end

    assign bus.out_valid      = ctrl_q.valid;
    assign bus.out_reg_write  = ctrl_q.reg_write;
    assign bus.out_mem_read   = ctrl_q.mem_read;
    assign bus.out_mem_write  = ctrl_q.mem_write;
    assign bus.out_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.branch_taken   = ctrl_q.branch_taken;
    assign bus.out_alu_result = alu_result_q;
    assign bus.out_store_data = store_data_q;
    assign bus.out_dest_reg   = dest_reg_q;
    assign bus.flag_n         = flags_q.n;
    assign bus.flag_z         = flags_q.z;
    assign bus.flag_c         = flags_q.c;
    assign bus.flag_v         = flags_q.v;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning datapath width.
REQ-002 SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-003 SHALL have clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have stall  input  1  hold all state this cycle.
REQ-006 SHALL have flush  input  1  insert bubble; overrides stall.
REQ-007 SHALL have in_valid  input  1  EX-stage instruction valid.
REQ-008 SHALL have alu_result  input  WIDTH  ALU output (incl. bitwise XOR/AND/OR results).
REQ-009 SHALL have alu_carry, alu_overflow  input  1 each  ALU carry-out and signed overflow.
REQ-010 SHALL have set_flags, is_cbz, is_bcond  input  1 each  instruction-class controls.
REQ-011 SHALL have cond  input  4  B.cond condition code.
REQ-012 SHALL have store_data  input  WIDTH  Rt value for STUR.
REQ-013 SHALL have dest_reg  input  REG_W  destination register.
REQ-014 SHALL have reg_write, mem_read, mem_write, mem_to_reg  input  1 each  MEM/WB controls.
REQ-015 SHALL have out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  1 each  registered controls.
REQ-016 SHALL have out_alu_result, out_store_data  output  WIDTH  registered data.
REQ-017 SHALL have out_dest_reg  output  REG_W  registered destination.
REQ-018 SHALL have flag_n, flag_z, flag_c, flag_v  output  1 each  architectural flag register.
REQ-019 SHALL have branch_taken  output  1  registered branch decision.

Function
REQ-020 SHALL compute z = NOR-reduction of alu_result and n = alu_result[WIDTH-1], combinationally.
REQ-021 SHALL load {n,z,alu_carry,alu_overflow} into the flag register on an edge where in_valid & set_flags & !stall & !flush; otherwise the flags hold.
REQ-022 SHALL evaluate B.cond against the flag register as held before the edge (no same-instruction bypass): EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !(C&!Z); GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 !(!Z&(N==V)); 1110/1111 always.
REQ-023 SHALL register branch_taken = in_valid & ((is_bcond & cond_true) | (is_cbz & z)).
REQ-024 SHALL, with !stall & !flush, register all data/control inputs with 1-cycle latency; every control output SHALL equal its input ANDed with in_valid.
REQ-025 SHALL, on stall & !flush, hold every output and the flag register unchanged.
REQ-026 SHALL, on flush (with or without stall), clear out_valid, all control outputs and branch_taken at the next edge; data outputs don't-care; flags unchanged.
REQ-027 SHALL never assert out_mem_read and out_mem_write together; if both inputs are high, out_mem_write wins and out_mem_read is cleared.

Reset
REQ-028 SHALL asynchronously clear all outputs, data registers and the flag register to 0 while reset is high, independent of clk.
REQ-029 SHALL, on reset mid-operation, discard the in-flight instruction; the first edge after deassertion behaves per REQ-024..026.

Structure
REQ-030 SHALL place cond encodings (enum cond_t) and a flags_t struct {n,z,c,v} in shared package pipeline_pkg.
REQ-031 SHALL implement condition evaluation as sub-module cond_check (cond, flags -> cond_true), purely combinational.

Verification
REQ-032 SUBS giving alu_result=0, carry=1, set_flags=1 -> next cycle flags N0 Z1 C1 V0; following B.cond EQ -> branch_taken=1.
REQ-033 alu_result=64'h8000_0000_0000_0000, overflow=1, set_flags -> N1 V1; then B.cond GE -> taken; LT -> not taken.
REQ-034 CBZ with alu_result=0 -> branch_taken=1; alu_result=5 -> 0; set_flags=0 leaves flags unchanged.
REQ-035 stall held 3 cycles with changing inputs -> outputs frozen; flush+stall together -> out_valid=0, out_reg_write=0 next cycle.
REQ-036 reset pulsed asynchronously between edges mid-stream -> all outputs 0 immediately; first valid ADD after release appears 1 cycle later with dest_reg intact.
